// File: rtl/seven_seg_scan_decoder.sv
// Receive-side monitor for a multiplexed 4-digit active-low seven-segment bus.
// Debounces each scanned digit, decodes it back to a 4-bit code and flags frames.
module seven_seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  segment,        // MSB-first a..g, active-low
  input  logic [3:0]  anodes,
  input  logic        decimal_point,
  output logic [15:0] digits,
  output logic [3:0]  dp_seen,
  output logic        capture_strobe,
  output logic        frame_valid,
  output logic        bad_pattern,
  output logic        scan_lost
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntHold = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [ToW-1:0]  ToMax   = ToW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StDwell, StHeld} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [ToW-1:0]  tcnt_q, tcnt_d;
  logic [11:0]     sample_q, prev_q;
  logic [15:0]     digits_q, digits_d;
  logic [3:0]      dp_q, dp_d;
  logic [3:0]      seen_q, seen_d;
  logic            strobe_q, frame_q, frame_d, bad_q;

  logic [3:0] s_an;
  logic [6:0] s_seg;
  logic       s_dp, s_valid, s_same, capture;
  logic [1:0] slot;
  logic [3:0] code;

  assign s_an    = sample_q[11:8];
  assign s_seg   = sample_q[7:1];
  assign s_dp    = sample_q[0];
  assign s_valid = $onehot(~s_an);
  assign s_same  = (sample_q == prev_q);

  // Reset value is an all-off ghost so nothing looks stable out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q <= '1;
      prev_q   <= '1;
    end else begin
      prev_q   <= sample_q;
      sample_q <= {anodes, segment, decimal_point};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s_valid) begin
          state_d = StDwell;
          cnt_d   = CntW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      StDwell: begin
        if (s_same) begin
          if (cnt_q == CntLast) begin
            state_d = StHeld;
            cnt_d   = CntHold;
            capture = 1'b1;
          end else begin
            cnt_d   = cnt_q + CntW'(1);
          end
        end else if (s_valid) begin
          cnt_d   = CntW'(1);
        end else begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StHeld: begin
        if (!s_same) begin
          state_d = s_valid ? StDwell : StIdle;
          cnt_d   = s_valid ? CntW'(1) : '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    slot = '0;
    for (int i = 0; i < 4; i++) begin
      if (!s_an[i]) slot = 2'(i);
    end
  end

  always_comb begin
    case (s_seg)
      7'b0000001: code = 4'h0;
      7'b1001111: code = 4'h1;
      7'b0010010: code = 4'h2;
      7'b0000110: code = 4'h3;
      7'b1001100: code = 4'h4;
      7'b0100100: code = 4'h5;
      7'b0100000: code = 4'h6;
      7'b0001111: code = 4'h7;
      7'b0000000: code = 4'h8;
      7'b0000100: code = 4'h9;
      7'b1111111: code = 4'hF;
      default:    code = 4'hE;
    endcase
  end

  always_comb begin
    digits_d = digits_q;
    dp_d     = dp_q;
    seen_d   = seen_q;
    frame_d  = 1'b0;
    tcnt_d   = (tcnt_q == ToMax) ? tcnt_q : tcnt_q + ToW'(1);
    if (capture) begin
      digits_d[{slot, 2'b00} +: 4] = code;
      dp_d[slot]   = ~s_dp;
      seen_d[slot] = 1'b1;
      tcnt_d       = '0;
      // The completing capture belongs to the frame it closes.
      if (seen_d == 4'hF) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      digits_q <= 16'hFFFF;
      dp_q     <= '0;
      seen_q   <= '0;
      strobe_q <= 1'b0;
      frame_q  <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      digits_q <= digits_d;
      dp_q     <= dp_d;
      seen_q   <= seen_d;
      strobe_q <= capture;
      frame_q  <= frame_d;
      bad_q    <= capture && (code == 4'hE);
    end
  end

  assign digits         = digits_q;
  assign dp_seen        = dp_q;
  assign capture_strobe = strobe_q;
  assign frame_valid    = frame_q;
  assign bad_pattern    = bad_q;
  assign scan_lost      = (tcnt_q == ToMax);

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder: directed vector table, corner sequences and a
// randomized run against a run-length based reference model.
module tb_seven_seg_scan_decoder;

  localparam int unsigned STABLE  = 16;
  localparam int unsigned TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  segment;
  logic [3:0]  anodes;
  logic        decimal_point;
  logic [15:0] digits;
  logic [3:0]  dp_seen;
  logic        capture_strobe, frame_valid, bad_pattern, scan_lost;

  int checks = 0;
  int errors = 0;

  seven_seg_scan_decoder #(
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .segment       (segment),
    .anodes        (anodes),
    .decimal_point (decimal_point),
    .digits        (digits),
    .dp_seen       (dp_seen),
    .capture_strobe(capture_strobe),
    .frame_valid   (frame_valid),
    .bad_pattern   (bad_pattern),
    .scan_lost     (scan_lost)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  function automatic logic [3:0] ref_decode(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (s == seg_tab[i]) return 4'(i);
    if (s == 7'b1111111) return 4'hF;
    return 4'hE;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    int          cycles;
    int          strobes;
    int          first;
    int          frames;
    int          bads;
    logic [15:0] dig;
    logic [3:0]  dps;
    logic        lost;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ns, nf, nb, alone, first, k;
    logic [11:0] v, prev;
    int rl, since, hold;
    bit pend, ok;
    logic [11:0] pend_v;
    logic [15:0] m_dig;
    logic [3:0] m_dp, m_seen, an;
    logic [1:0] slot;
    logic [3:0] code;
    logic exp_bad, exp_frame;

    // an, seg, dp, cycles, strobes, first, frames, bads, digits, dp_seen, scan_lost
    vecs[0] = '{4'b1110, 7'b1001100, 1'b1, 64,  1, 17, 0, 0, 16'hFFF4, 4'b0000, 1'b0};
    vecs[1] = '{4'b1101, 7'b0000110, 1'b1, 64,  1, 17, 0, 0, 16'hFF34, 4'b0000, 1'b0};
    vecs[2] = '{4'b1011, 7'b0010010, 1'b0, 64,  1, 17, 0, 0, 16'hF234, 4'b0100, 1'b0};
    vecs[3] = '{4'b0111, 7'b1001111, 1'b1, 64,  1, 17, 1, 0, 16'h1234, 4'b0100, 1'b0};
    vecs[4] = '{4'b1100, 7'b0000000, 1'b1, 100, 0, 0,  0, 0, 16'h1234, 4'b0100, 1'b1};
    vecs[5] = '{4'b1111, 7'b1111111, 1'b1, 100, 0, 0,  0, 0, 16'h1234, 4'b0100, 1'b1};
    vecs[6] = '{4'b1011, 7'b1111110, 1'b1, 40,  1, 17, 0, 1, 16'h1E34, 4'b0000, 1'b0};
    vecs[7] = '{4'b1110, 7'b0001111, 1'b1, 200, 1, 17, 0, 0, 16'h1E37, 4'b0000, 1'b1};
    vecs[8] = '{4'b1101, 7'b1111111, 1'b0, 30,  1, 17, 0, 0, 16'h1EF7, 4'b0010, 1'b0};
    vecs[9] = '{4'b0111, 7'b0000100, 1'b1, 30,  1, 17, 1, 0, 16'h9EF7, 4'b0010, 1'b0};

    rst = 1'b1;
    anodes = 4'hF; segment = 7'h7F; decimal_point = 1'b1;
    repeat (3) tick();
    check("reset_digits", digits, 16'hFFFF);
    check("reset_dp", dp_seen, 4'h0);
    check("reset_pulses", {capture_strobe, frame_valid, bad_pattern}, 3'b000);
    check("reset_lost", scan_lost, 1'b0);
    rst = 1'b0;

    for (int n = 0; n < 10; n++) begin
      anodes = vecs[n].an; segment = vecs[n].seg; decimal_point = vecs[n].dp;
      ns = 0; nf = 0; nb = 0; alone = 0; first = 0;
      for (int i = 1; i <= vecs[n].cycles; i++) begin
        tick();
        if (capture_strobe) begin
          ns++;
          if (first == 0) first = i;
        end
        if (frame_valid) nf++;
        if (bad_pattern) nb++;
        if (bad_pattern && !capture_strobe) alone++;
      end
      check($sformatf("v%0d_strobes", n), ns, vecs[n].strobes);
      check($sformatf("v%0d_first", n), first, vecs[n].first);
      check($sformatf("v%0d_frames", n), nf, vecs[n].frames);
      check($sformatf("v%0d_bads", n), nb, vecs[n].bads);
      check($sformatf("v%0d_bad_alone", n), alone, 0);
      check($sformatf("v%0d_digits", n), digits, vecs[n].dig);
      check($sformatf("v%0d_dp", n), dp_seen, vecs[n].dps);
      check($sformatf("v%0d_lost", n), scan_lost, vecs[n].lost);
    end

    // Glitch every 10th cycle on digit 1 never lets a run reach STABLE.
    anodes = 4'b1101; decimal_point = 1'b1;
    ns = 0;
    for (int i = 0; i < 120; i++) begin
      segment = (i % 10 == 9) ? seg_tab[6] : seg_tab[5];
      tick();
      if (capture_strobe) ns++;
    end
    check("glitch_strobes", ns, 0);
    check("glitch_digit1", digits[7:4], 4'hF);

    // Timeout: capture, then go dark.
    anodes = 4'b1110; segment = seg_tab[0]; decimal_point = 1'b1;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      ok = capture_strobe;
    end
    check("to_first_capture", ok, 1'b1);
    anodes = 4'hF; segment = 7'h7F;
    for (k = 1; k <= 150; k++) begin
      tick();
      if (k == 99)  check("to_lost_99", scan_lost, 1'b0);
      if (k == 100) check("to_lost_100", scan_lost, 1'b1);
    end
    check("to_lost_150", scan_lost, 1'b1);
    check("to_hold_digit0", digits[3:0], 4'h0);
    anodes = 4'b1110; segment = seg_tab[5];
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      ok = capture_strobe;
    end
    check("to_recapture", ok, 1'b1);
    check("to_lost_cleared", scan_lost, 1'b0);

    // Reset mid-dwell.
    anodes = 4'b1101; segment = seg_tab[3];
    repeat (8) tick();
    #2 rst = 1'b1;
    #1;
    check("rst_mid_digits", digits, 16'hFFFF);
    check("rst_mid_strobe", capture_strobe, 1'b0);
    ns = 0;
    repeat (3) begin
      tick();
      if (capture_strobe) ns++;
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (capture_strobe) ns++;
    end
    check("rst_mid_no_capture", ns, 0);
    check("rst_mid_digits_after", digits, 16'hFFFF);

    // Randomized run against a run-length reference model.
    rst = 1'b1;
    anodes = 4'hF; segment = 7'h7F; decimal_point = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    prev = 12'hFFF; rl = 0; since = 0; pend = 0; pend_v = '0; hold = 0; v = 12'hFFF;
    m_dig = 16'hFFFF; m_dp = '0; m_seen = '0;
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        k = $urandom_range(0, 9);
        an = ~(4'b0001 << $urandom_range(0, 3));
        if (k <= 6)      v = {an, seg_tab[$urandom_range(0, 9)], 1'($urandom)};
        else if (k == 7) v = {an, 7'h7F, 1'($urandom)};
        else if (k == 8) v = {an, 7'($urandom), 1'($urandom)};
        else begin
          an = 4'($urandom);
          if ($countones(~an) == 1) an = 4'hF;
          v = {an, seg_tab[$urandom_range(0, 9)], 1'($urandom)};
        end
        hold = $urandom_range(1, 40);
      end
      hold--;
      {anodes, segment, decimal_point} = v;
      tick();
      exp_bad = 0; exp_frame = 0;
      if (pend) begin
        slot = '0;
        for (int i = 0; i < 4; i++) if (!pend_v[8 + i]) slot = 2'(i);
        code = ref_decode(pend_v[7:1]);
        m_dig[{slot, 2'b00} +: 4] = code;
        m_dp[slot] = ~pend_v[0];
        m_seen[slot] = 1'b1;
        exp_bad = (code == 4'hE);
        if (m_seen == 4'hF) begin
          exp_frame = 1;
          m_seen = '0;
        end
        since = 0;
      end else if (since < TIMEOUT) begin
        since++;
      end
      check($sformatf("rnd%0d_flags", n), {capture_strobe, bad_pattern, frame_valid, scan_lost},
            {pend, exp_bad, exp_frame, since == TIMEOUT});
      check($sformatf("rnd%0d_digits", n), digits, m_dig);
      check($sformatf("rnd%0d_dp", n), dp_seen, m_dp);
      rl = (v == prev) ? rl + 1 : 1;
      prev = v;
      pend = ($countones(~v[11:8]) == 1) && (rl == STABLE);
      pend_v = v;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
